pcim_cmd_sched: RTL and testbench

- Per-channel command scheduler in front of the PCIM DMA engine.
- Accepts SoftReg-posted PCIM_CMD words into 4 channel queues.
- Round-robin picks an eligible channel and issues one command at a time over a valid/ready port.
- Limits in-flight 4 KB pages per channel, using page-completion feedback from the engine's B-response path.

---
 rtl/pcim_pkg.sv | 46 ++++
 rtl/pcim_rr_pick.sv | 27 ++
 rtl/pcim_cmd_sched.sv | 216 +++++++++++++++++++++
 tb/tb_pcim_cmd_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcim_pkg.sv
// Shared PCIM definitions: command word layout, SoftReg transport structs and
// the command scheduler register map.
package pcim_pkg;

   localparam int PCIM_NUM_CH = 4;

   localparam logic [63:0] PCIM_SCHED_Q_BASE    = 64'h1000;
   localparam logic [63:0] PCIM_SCHED_LIM_BASE  = 64'h1040;
   localparam logic [63:0] PCIM_SCHED_ERR       = 64'h1080;
   localparam logic [63:0] PCIM_SCHED_STAT_BASE = 64'h10C0;

   // count is in 64-byte lines, so count[15:6] is the 4 KB page index.
   typedef struct packed {
      logic [1:0]  channel;
      logic [7:0]  rsvd;
      logic [15:0] count;
      logic [37:0] addr;
   } PCIM_CMD;

   typedef struct packed {
      logic        valid;
      logic        isWrite;
      logic [63:0] addr;
      logic [63:0] data;
   } SoftRegReq;

   typedef struct packed {
      logic        valid;
      logic [63:0] data;
   } SoftRegResp;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } sched_state_e;

   function automatic logic [10:0] pcim_pages(input PCIM_CMD c);
      return 11'(c.count[15:6]) + 11'd1;
   endfunction

   // Matches a per-channel register bank of four 8-byte slots at base.
   function automatic logic sr_bank_hit(input logic [63:0] addr, input logic [63:0] base);
      return (addr[63:5] == base[63:5]) && (addr[2:0] == 3'b000);
   endfunction

endpackage

// File: rtl/pcim_rr_pick.sv
// Four-way round-robin picker: first eligible channel after ptr_i, wrapping.
module pcim_rr_pick (
   input  logic [3:0] elig_i,
   input  logic [1:0] ptr_i,
   output logic [1:0] grant_o,
   output logic       any_o
);

   logic [1:0] idx [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_idx
      assign idx[gi] = ptr_i + 2'(gi + 1);
   end

   // Scan farthest-first so the nearest eligible candidate is the last to win.
   always_comb begin
      grant_o = 2'd0;
      any_o   = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         if (elig_i[idx[k]]) begin
            grant_o = idx[k];
            any_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcim_cmd_sched.sv
// Per-channel PCIM command scheduler with in-flight page limiting.
// Optional per-channel statistics counters: define PCIM_SCHED_STATS_EN.
module pcim_cmd_sched
   import pcim_pkg::*;
#(
   parameter int NUM_CH    = PCIM_NUM_CH,
   parameter int Q_LD      = 5,
   parameter int MAX_PAGES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  SoftRegReq   softreg_req,
   output SoftRegResp  softreg_resp,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [63:0] cmd_data,
   input  logic        cpl_valid,
   input  logic [1:0]  cpl_channel
);

   localparam int QD = 1 << Q_LD;

   logic              wr_en, rd_en, q_hit, lim_hit, err_hit, err_clr;
   logic [1:0]        ch_sel;
   PCIM_CMD           head       [NUM_CH];
   logic [Q_LD-1:0]   level      [NUM_CH];
   logic [10:0]       head_pages [NUM_CH];
   logic [NUM_CH-1:0] elig, pop, ovf_set;
   logic [15:0]       out_q [NUM_CH], out_d [NUM_CH];
   logic [15:0]       lim_q [NUM_CH], lim_d [NUM_CH];
   logic [16:0]       acc   [NUM_CH];
   logic [NUM_CH-1:0] err_ovf_q, err_ovf_d, err_unf_q, err_unf_d;
   logic [1:0]        grant, grant_q, ptr_q;
   logic              any_elig, issue_fire;
   logic [10:0]       pages_q;
   PCIM_CMD           issue_cmd;
   logic [63:0]       cmd_data_q, rd_data;
   SoftRegResp        resp_q;
   sched_state_e      state_q, state_d;

   assign wr_en   = softreg_req.valid && softreg_req.isWrite;
   assign rd_en   = softreg_req.valid && !softreg_req.isWrite;
   assign ch_sel  = softreg_req.addr[4:3];
   assign q_hit   = sr_bank_hit(softreg_req.addr, PCIM_SCHED_Q_BASE);
   assign lim_hit = sr_bank_hit(softreg_req.addr, PCIM_SCHED_LIM_BASE);
   assign err_hit = (softreg_req.addr == PCIM_SCHED_ERR);
   assign err_clr = wr_en && err_hit;

   // One slot is sacrificed so full/empty need no extra pointer bit.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [63:0]     mem [QD];
      logic [Q_LD-1:0] wr_ptr_q, rd_ptr_q;
      logic            wr_hit, full, enq;
      logic [16:0]     sum;

      assign wr_hit         = wr_en && q_hit && (ch_sel == 2'(gi));
      assign level[gi]      = wr_ptr_q - rd_ptr_q;
      assign full           = (level[gi] == Q_LD'(QD - 1));
      assign enq            = wr_hit && !full;
      assign ovf_set[gi]    = wr_hit && full;
      assign head[gi]       = PCIM_CMD'(mem[rd_ptr_q]);
      assign head_pages[gi] = pcim_pages(head[gi]);
      assign sum            = 17'(out_q[gi]) + 17'(head_pages[gi]);
      assign elig[gi]       = (level[gi] != '0) && (lim_q[gi] != '0) &&
                              ((out_q[gi] == '0) || (sum <= 17'(lim_q[gi])));

      always_ff @(posedge clk) begin
         if (enq) mem[wr_ptr_q] <= softreg_req.data;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (enq)     wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop[gi]) rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   pcim_rr_pick u_pick (
      .elig_i  (elig),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .any_o   (any_elig)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (any_elig)  state_d = S_ISSUE;
         S_ISSUE: if (cmd_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pop               = '0;
      issue_fire        = (state_q == S_ISSUE) && cmd_ready;
      cmd_valid         = (state_q == S_ISSUE);
      issue_cmd         = head[grant];
      issue_cmd.channel = grant;
      if (state_q == S_IDLE && any_elig) pop[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_data_q <= '0;
         grant_q    <= '0;
         pages_q    <= '0;
         ptr_q      <= 2'd3;
      end else begin
         if (pop != '0) begin
            cmd_data_q <= issue_cmd;
            grant_q    <= grant;
            pages_q    <= head_pages[grant];
         end
         if (issue_fire) ptr_q <= grant_q;
      end
   end

   assign cmd_data = cmd_data_q;

   // Issue and completion on one channel net out; the 17-bit sum then saturates.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         acc[c] = 17'(out_q[c]) + ((issue_fire && grant_q == 2'(c)) ? 17'(pages_q) : 17'd0);
         err_unf_d[c] = err_clr ? 1'b0 : err_unf_q[c];
         err_ovf_d[c] = (err_clr ? 1'b0 : err_ovf_q[c]) | ovf_set[c];
         if (cpl_valid && cpl_channel == 2'(c)) begin
            if (acc[c] == '0) err_unf_d[c] = 1'b1;
            else              acc[c] = acc[c] - 17'd1;
         end
         out_d[c] = acc[c][16] ? 16'hFFFF : acc[c][15:0];
         lim_d[c] = (wr_en && lim_hit && ch_sel == 2'(c)) ? softreg_req.data[15:0] : lim_q[c];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_ovf_q <= '0;
         err_unf_q <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            out_q[c] <= '0;
            lim_q[c] <= 16'(MAX_PAGES);
         end
      end else begin
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
         for (int c = 0; c < NUM_CH; c++) begin
            out_q[c] <= out_d[c];
            lim_q[c] <= lim_d[c];
         end
      end
   end

`ifdef PCIM_SCHED_STATS_EN
   logic        stat_hit;
   logic [31:0] st_cmds_q  [NUM_CH];
   logic [31:0] st_pages_q [NUM_CH];

   assign stat_hit = sr_bank_hit(softreg_req.addr, PCIM_SCHED_STAT_BASE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            st_cmds_q[c]  <= '0;
            st_pages_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && stat_hit && ch_sel == 2'(c)) begin
               st_cmds_q[c]  <= '0;
               st_pages_q[c] <= '0;
            end else if (issue_fire && grant_q == 2'(c)) begin
               st_cmds_q[c]  <= st_cmds_q[c] + 32'd1;
               st_pages_q[c] <= st_pages_q[c] + 32'(pages_q);
            end
         end
      end
   end
`endif

   always_comb begin
      rd_data = '0;
      if (q_hit) begin
         rd_data = {8'h0, err_ovf_q[ch_sel], err_unf_q[ch_sel], 6'h0,
                    16'(level[ch_sel]), lim_q[ch_sel], out_q[ch_sel]};
      end else if (err_hit) begin
         rd_data = {62'h0, |err_unf_q, |err_ovf_q};
      end
`ifdef PCIM_SCHED_STATS_EN
      else if (stat_hit) begin
         rd_data = {st_pages_q[ch_sel], st_cmds_q[ch_sel]};
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_q <= '0;
      end else begin
         resp_q.valid <= rd_en;
         if (rd_en) resp_q.data <= rd_data;
      end
   end

   assign softreg_resp = resp_q;

endmodule

// File: tb/tb_pcim_cmd_sched.sv
// Self-checking bench for pcim_cmd_sched: vector table plus scoreboarded issue port.
module tb_pcim_cmd_sched;
   import pcim_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   SoftRegReq   req;
   SoftRegResp  resp;
   logic        cmd_valid, cmd_ready;
   logic [63:0] cmd_data;
   logic        cpl_valid;
   logic [1:0]  cpl_channel;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q [$];

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] count;
      int          exp_pages;
   } vec_t;
   vec_t vecs [6];

   localparam logic [63:0] IDLE_WORD = 64'h0000_0000_0020_0000;

   always #5 clk = ~clk;

   pcim_cmd_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .softreg_req  (req),
      .softreg_resp (resp),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_data     (cmd_data),
      .cpl_valid    (cpl_valid),
      .cpl_channel  (cpl_channel)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sr_write(input logic [63:0] addr, input logic [63:0] data);
      req.valid = 1'b1; req.isWrite = 1'b1; req.addr = addr; req.data = data;
      tick();
      req.valid = 1'b0; req.isWrite = 1'b0;
   endtask

   task automatic sr_read(input logic [63:0] addr, output logic [63:0] data);
      req.valid = 1'b1; req.isWrite = 1'b0; req.addr = addr;
      tick();
      req.valid = 1'b0;
      check("resp_valid", 64'(resp.valid), 64'd1);
      data = resp.data;
   endtask

   task automatic chk_reg(input string name, input logic [63:0] addr, input logic [63:0] exp);
      logic [63:0] d;
      sr_read(addr, d);
      check(name, d, exp);
   endtask

   task automatic chk_out(input int ch, input int exp);
      logic [63:0] d;
      sr_read(PCIM_SCHED_Q_BASE + 64'(8 * ch), d);
      check($sformatf("outstanding[%0d]", ch), 64'(d[15:0]), 64'(exp));
   endtask

   // Channel field is deliberately wrong in the posted word; the DUT must overwrite it.
   task automatic enq(input int ch, input logic [15:0] count, input bit push);
      PCIM_CMD c, e;
      c.addr    = {6'($urandom), 32'($urandom)};
      c.rsvd    = 8'($urandom);
      c.count   = count;
      c.channel = ~2'(ch);
      sr_write(PCIM_SCHED_Q_BASE + 64'(8 * ch), c);
      e = c;
      e.channel = 2'(ch);
      if (push) exp_q.push_back(e);
   endtask

   task automatic cpl(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         cpl_valid = 1'b1; cpl_channel = 2'(ch);
         tick();
         cpl_valid = 1'b0;
      end
   endtask

   task automatic drain(input string name, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got %h expected no command", cmd_data);
         end else begin
            check("issue_data", cmd_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      vecs[0] = '{ch: 2'd2, count: 16'd0,     exp_pages: 1};
      vecs[1] = '{ch: 2'd0, count: 16'd63,    exp_pages: 1};
      vecs[2] = '{ch: 2'd1, count: 16'd64,    exp_pages: 2};
      vecs[3] = '{ch: 2'd3, count: 16'd191,   exp_pages: 3};
      vecs[4] = '{ch: 2'd2, count: 16'd639,   exp_pages: 10};
      vecs[5] = '{ch: 2'd0, count: 16'hFFFF,  exp_pages: 1024};

      req = '0; cmd_ready = 1'b0; cpl_valid = 1'b0; cpl_channel = 2'd0;
      #2;
      check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      check("rst_cmd_data", cmd_data, 64'd0);
      check("rst_resp_valid", 64'(resp.valid), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      for (int c = 0; c < 4; c++)
         chk_reg($sformatf("rst_word[%0d]", c), PCIM_SCHED_Q_BASE + 64'(8 * c), IDLE_WORD);
      chk_reg("rst_err", PCIM_SCHED_ERR, 64'd0);
      chk_reg("unmapped_read", 64'h2000, 64'd0);
`ifndef PCIM_SCHED_STATS_EN
      chk_reg("stats_absent", PCIM_SCHED_STAT_BASE, 64'd0);
`endif

      // Single commands: latency, channel overwrite, page arithmetic, completions.
      cmd_ready = 1'b1;
      foreach (vecs[i]) begin
         enq(vecs[i].ch, vecs[i].count, 1'b1);
         drain($sformatf("vec%0d_latency", i), 4);
         chk_out(vecs[i].ch, vecs[i].exp_pages);
         cpl(vecs[i].ch, vecs[i].exp_pages);
         chk_out(vecs[i].ch, 0);
      end

      // Round robin: two per channel, released together.
      cmd_ready = 1'b0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) enq(c, 16'd0, 1'b1);
      cmd_ready = 1'b1;
      drain("rr_drain", 40);
      for (int c = 0; c < 4; c++) chk_out(c, 2);
      for (int c = 0; c < 4; c++) cpl(c, 2);

      // Page limit: 3 + 3 exceeds 5, 2 + 3 does not.
      sr_write(PCIM_SCHED_LIM_BASE + 64'd8, 64'd5);
      enq(1, 16'd191, 1'b1);
      enq(1, 16'd191, 1'b1);
      repeat (10) tick();
      check("lim_blocked", 64'(exp_q.size()), 64'd1);
      chk_out(1, 3);
      cpl(1, 1);
      chk_out(1, 2);
      drain("lim_release", 10);
      chk_out(1, 5);
      cpl(1, 5);
      sr_write(PCIM_SCHED_LIM_BASE + 64'd8, 64'd32);

      // Oversized command proceeds from zero outstanding; follower waits for all pages.
      sr_write(PCIM_SCHED_LIM_BASE, 64'd2);
      enq(0, 16'd639, 1'b1);
      drain("big_issue", 6);
      chk_out(0, 10);
      enq(0, 16'd191, 1'b1);
      cpl(0, 9);
      repeat (4) tick();
      check("big_blocked", 64'(exp_q.size()), 64'd1);
      chk_out(0, 1);
      cpl(0, 1);
      drain("big_release", 6);
      chk_out(0, 3);
      cpl(0, 3);
      sr_write(PCIM_SCHED_LIM_BASE, 64'd32);

      // Overflow: one held in the output register, 31 queued, the 33rd dropped.
      cmd_ready = 1'b0;
      for (int i = 0; i < 33; i++) enq(3, 16'd0, i < 32);
      chk_reg("ovf_word3", PCIM_SCHED_Q_BASE + 64'd24, 64'h0080_001F_0020_0000);
      chk_reg("ovf_err", PCIM_SCHED_ERR, 64'd1);
      sr_write(PCIM_SCHED_ERR, 64'd0);
      chk_reg("err_cleared", PCIM_SCHED_ERR, 64'd0);
      cpl(0, 1);
      chk_reg("unf_err", PCIM_SCHED_ERR, 64'd2);
      chk_reg("unf_word0", PCIM_SCHED_Q_BASE, 64'h0040_0000_0020_0000);
      cmd_ready = 1'b1;
      drain("ovf_drain", 100);
      chk_out(3, 32);

      // Reset while a command is held and ch1 has five queued.
      cmd_ready = 1'b0;
      for (int i = 0; i < 6; i++) enq(1, 16'd0, 1'b0);
      check("pre_rst_valid", 64'(cmd_valid), 64'd1);
      sr_read(PCIM_SCHED_Q_BASE + 64'd8, d);
      check("pre_rst_level1", 64'(d[47:32]), 64'd5);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(cmd_valid), 64'd0);
      check("async_rst_data", cmd_data, 64'd0);
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      for (int c = 0; c < 4; c++)
         chk_reg($sformatf("post_rst_word[%0d]", c), PCIM_SCHED_Q_BASE + 64'(8 * c), IDLE_WORD);
      chk_reg("post_rst_err", PCIM_SCHED_ERR, 64'd0);
      repeat (4) tick();
      check("post_rst_idle", 64'(cmd_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
